mod_counter: RTL and testbench



---
 rtl/mod_counter_pkg.sv | 26 ++
 rtl/mod_counter_bcd.sv | 23 ++
 rtl/mod_counter.sv | 129 ++++++++++++
 tb/tb_mod_counter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/mod_counter_pkg.sv
// Shared types and helpers for the modulo-N counter.
// The BCD helper is only instantiated when MOD_COUNTER_BCD_EN is defined.
package mod_counter_pkg;

   typedef enum logic [1:0] {
      OP_HOLD,
      OP_INC,
      OP_DEC,
      OP_LOAD
   } cnt_op_e;

   localparam int unsigned BCD_MAX_MODULUS = 100;

   // Valid for 0..99; the tens digit is found by threshold search, so no divider is needed.
   function automatic logic [7:0] bin2bcd2(input logic [6:0] bin);
      logic [3:0] tens;
      logic [6:0] rem;
      tens = '0;
      for (int unsigned i = 1; i < 10; i++) begin
         if (bin >= 7'(i * 10)) tens = 4'(i);
      end
      rem = bin - (7'(tens) * 7'd10);
      return {tens, rem[3:0]};
   endfunction

endpackage

// File: rtl/mod_counter_bcd.sv
// Combinational two-digit BCD view of a counter value (0..99).
// Only instantiated by mod_counter when MOD_COUNTER_BCD_EN is defined.
module mod_counter_bcd
   import mod_counter_pkg::*;
#(
   parameter int unsigned WIDTH = 6
) (
   input  logic [WIDTH-1:0] i_count,
   output logic [3:0]       o_tens,
   output logic [3:0]       o_units
);

   logic [6:0] w_bin;
   logic [7:0] w_bcd;

   always_comb begin
      w_bin   = 7'(i_count);
      w_bcd   = bin2bcd2(w_bin);
      o_tens  = w_bcd[7:4];
      o_units = w_bcd[3:0];
   end

endmodule

// File: rtl/mod_counter.sv
// Parametrised modulo-N up/down counter with load, wrap pulses and compare match.
// Define MOD_COUNTER_BCD_EN to add the bcd_tens_o/bcd_units_o outputs.
module mod_counter
   import mod_counter_pkg::*;
#(
   parameter int unsigned MODULUS   = 24,
   parameter int unsigned WIDTH     = 6,
   parameter int unsigned RESET_VAL = 0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc_i,
   input  logic             dec_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic [WIDTH-1:0] cmp_val_i,
   output logic [WIDTH-1:0] count_o,
   output logic             carry_o,
   output logic             borrow_o,
   output logic             load_err_o,
   output logic             match_o
`ifdef MOD_COUNTER_BCD_EN
   ,
   output logic [3:0]       bcd_tens_o,
   output logic [3:0]       bcd_units_o
`endif
);

   if (MODULUS < 2) begin : g_chk_modulus
      $error("mod_counter: MODULUS must be 2 or more");
   end
   if ((WIDTH < 32) && ((64'd1 << WIDTH) < 64'(MODULUS))) begin : g_chk_width
      $error("mod_counter: WIDTH too narrow for MODULUS");
   end
   if (RESET_VAL >= MODULUS) begin : g_chk_reset_val
      $error("mod_counter: RESET_VAL must be less than MODULUS");
   end

   // One extra bit so MODULUS == 2**WIDTH still compares correctly.
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RESET_VAL);

   cnt_op_e          w_op;
   logic             w_load_ok;
   logic [WIDTH-1:0] w_count_nxt;
   logic             w_carry_nxt;
   logic             w_borrow_nxt;
   logic             w_err_nxt;

   logic [WIDTH-1:0] r_count;
   logic             r_carry;
   logic             r_borrow;
   logic             r_load_err;

   always_comb begin
      w_op = OP_HOLD;
      if (load_i)             w_op = OP_LOAD;
      else if (inc_i ^ dec_i) w_op = inc_i ? OP_INC : OP_DEC;
   end

   always_comb begin
      w_load_ok    = ({1'b0, load_val_i} < MOD_EXT);
      w_count_nxt  = r_count;
      w_carry_nxt  = 1'b0;
      w_borrow_nxt = 1'b0;
      w_err_nxt    = 1'b0;
      case (w_op)
         OP_LOAD: begin
            if (w_load_ok) w_count_nxt = load_val_i;
            else           w_err_nxt   = 1'b1;
         end
         OP_INC: begin
            if (r_count == LAST) begin
               w_count_nxt = '0;
               w_carry_nxt = 1'b1;
            end else begin
               w_count_nxt = r_count + 1'b1;
            end
         end
         OP_DEC: begin
            if (r_count == '0) begin
               w_count_nxt  = LAST;
               w_borrow_nxt = 1'b1;
            end else begin
               w_count_nxt = r_count - 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_count    <= RST_CNT;
         r_carry    <= 1'b0;
         r_borrow   <= 1'b0;
         r_load_err <= 1'b0;
      end else begin
         r_count    <= w_count_nxt;
         r_carry    <= w_carry_nxt;
         r_borrow   <= w_borrow_nxt;
         r_load_err <= w_err_nxt;
      end
   end

   always_comb begin
      count_o    = r_count;
      carry_o    = r_carry;
      borrow_o   = r_borrow;
      load_err_o = r_load_err;
      match_o    = (r_count == cmp_val_i) && ({1'b0, cmp_val_i} < MOD_EXT);
   end

`ifdef MOD_COUNTER_BCD_EN
   if (MODULUS > BCD_MAX_MODULUS) begin : g_chk_bcd
      $error("mod_counter: MODULUS too large for BCD outputs");
   end

   mod_counter_bcd #(
      .WIDTH (WIDTH)
   ) u_bcd (
      .i_count (r_count),
      .o_tens  (bcd_tens_o),
      .o_units (bcd_units_o)
   );
`endif

endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench for mod_counter (MODULUS=24, WIDTH=6, RESET_VAL=0).
// Checks BCD outputs too when MOD_COUNTER_BCD_EN is defined.
module tb_mod_counter;

   localparam int unsigned W = 6;

   typedef struct {
      string        name;
      logic [W-1:0] count;
      logic         carry;
      logic         borrow;
      logic         err;
      logic         match;
      logic [3:0]   tens;
      logic [3:0]   units;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         inc = 1'b0;
   logic         dec = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] load_val = '0;
   logic [W-1:0] cmp_val = 6'd40;
   logic [W-1:0] count;
   logic         carry, borrow, load_err, match;
`ifdef MOD_COUNTER_BCD_EN
   logic [3:0]   bcd_tens, bcd_units;
`endif

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   mod_counter #(
      .MODULUS   (24),
      .WIDTH     (6),
      .RESET_VAL (0)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .inc_i      (inc),
      .dec_i      (dec),
      .load_i     (load),
      .load_val_i (load_val),
      .cmp_val_i  (cmp_val),
      .count_o    (count),
      .carry_o    (carry),
      .borrow_o   (borrow),
      .load_err_o (load_err),
      .match_o    (match)
`ifdef MOD_COUNTER_BCD_EN
      ,
      .bcd_tens_o  (bcd_tens),
      .bcd_units_o (bcd_units)
`endif
   );

   // Drive one cycle of stimulus at the falling edge and queue its post-edge expectation.
   task automatic vec(input string nm, input logic r, input logic i, input logic d,
                      input logic l, input logic [W-1:0] lv, input logic [W-1:0] cv,
                      input logic [W-1:0] ec, input logic ecar, input logic ebor,
                      input logic eerr, input logic emat, input int unsigned bcd);
      exp_t e;
      @(negedge clk);
      rst = r; inc = i; dec = d; load = l; load_val = lv; cmp_val = cv;
      e.name = nm; e.count = ec; e.carry = ecar; e.borrow = ebor; e.err = eerr;
      e.match = emat;
      e.tens  = 4'(bcd / 10);
      e.units = 4'(bcd % 10);
      sb.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      int   bad;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() != 0) begin
            e   = sb.pop_front();
            bad = 0;
            n_vec++;
            if (count !== e.count) begin
               $display("FAIL %s count: got %0d want %0d", e.name, count, e.count); bad = 1;
            end
            if (carry !== e.carry) begin
               $display("FAIL %s carry: got %b want %b", e.name, carry, e.carry); bad = 1;
            end
            if (borrow !== e.borrow) begin
               $display("FAIL %s borrow: got %b want %b", e.name, borrow, e.borrow); bad = 1;
            end
            if (load_err !== e.err) begin
               $display("FAIL %s load_err: got %b want %b", e.name, load_err, e.err); bad = 1;
            end
            if (match !== e.match) begin
               $display("FAIL %s match: got %b want %b", e.name, match, e.match); bad = 1;
            end
`ifdef MOD_COUNTER_BCD_EN
            if (bcd_tens !== e.tens || bcd_units !== e.units) begin
               $display("FAIL %s bcd: got %0d%0d want %0d%0d", e.name, bcd_tens, bcd_units,
                        e.tens, e.units);
               bad = 1;
            end
`endif
            n_err += bad;
         end
      end
   end

   initial begin : driver
      int unsigned c;
      // name           rst inc dec ld  lval   cmp    cnt  car bor err mat bcd
      vec("reset",        1, 0, 0, 0, 6'd0,  6'd40, 6'd0, 0, 0, 0, 0, 0);
      for (int unsigned k = 0; k < 24; k++) begin
         c = (k + 1) % 24;
         vec("inc_wrap",  0, 1, 0, 0, 6'd0,  6'd40, 6'(c), (k == 23), 0, 0, 0, c);
      end
      vec("hold_after",   0, 0, 0, 0, 6'd0,  6'd40, 6'd0, 0, 0, 0, 0, 0);
      vec("reset2",       1, 0, 0, 0, 6'd0,  6'd40, 6'd0, 0, 0, 0, 0, 0);
      vec("dec_wrap",     0, 0, 1, 0, 6'd0,  6'd40, 6'd23, 0, 1, 0, 0, 23);
      vec("dec_plain",    0, 0, 1, 0, 6'd0,  6'd40, 6'd22, 0, 0, 0, 0, 22);
      vec("load17_inc",   0, 1, 0, 1, 6'd17, 6'd40, 6'd17, 0, 0, 0, 0, 17);
      vec("load30_bad",   0, 0, 1, 1, 6'd30, 6'd40, 6'd17, 0, 0, 1, 0, 17);
      vec("err_clears",   0, 0, 0, 0, 6'd0,  6'd40, 6'd17, 0, 0, 0, 0, 17);
      vec("load24_bad",   0, 0, 0, 1, 6'd24, 6'd40, 6'd17, 0, 0, 1, 0, 17);
      vec("load23_ok",    0, 0, 0, 1, 6'd23, 6'd40, 6'd23, 0, 0, 0, 0, 23);
      vec("inc_dec_hold", 0, 1, 1, 0, 6'd0,  6'd40, 6'd23, 0, 0, 0, 0, 23);
      vec("rst_override", 1, 1, 0, 1, 6'd9,  6'd40, 6'd0,  0, 0, 0, 0, 0);
      vec("load5",        0, 0, 0, 1, 6'd5,  6'd7,  6'd5,  0, 0, 0, 0, 5);
      vec("up6",          0, 1, 0, 0, 6'd0,  6'd7,  6'd6,  0, 0, 0, 0, 6);
      vec("up7_match",    0, 1, 0, 0, 6'd0,  6'd7,  6'd7,  0, 0, 0, 1, 7);
      vec("up8",          0, 1, 0, 0, 6'd0,  6'd7,  6'd8,  0, 0, 0, 0, 8);
      vec("load7_cmp40",  0, 0, 0, 1, 6'd7,  6'd40, 6'd7,  0, 0, 0, 0, 7);
      vec("load1",        0, 0, 0, 1, 6'd1,  6'd0,  6'd1,  0, 0, 0, 0, 1);
      vec("dec_to0",      0, 0, 1, 0, 6'd0,  6'd0,  6'd0,  0, 0, 0, 1, 0);
      vec("load19_bcd",   0, 0, 0, 1, 6'd19, 6'd19, 6'd19, 0, 0, 0, 1, 19);
      vec("idle",         0, 0, 0, 0, 6'd0,  6'd40, 6'd19, 0, 0, 0, 0, 19);
      for (int unsigned t = 0; t < 10 && sb.size() != 0; t++) @(posedge clk);
      @(posedge clk);
      #2;
      if (sb.size() != 0) begin
         $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
         n_err++;
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
